// File: rtl/video_timing_pkg.sv
// Shared video timing definitions for the BT.656 scrambler front end:
// lock-state encodings, default field-length window and counter widths.
package video_timing_pkg;

    // Lock qualification states reported on lock_state
    typedef enum logic [1:0] {
        LS_SEARCH  = 2'd0,
        LS_MEASURE = 2'd1,
        LS_LOCKED  = 2'd2
    } lock_state_e;

    // Nominal lines per field for the two supported systems
    localparam int LINES_PER_FIELD_525 = 263;
    localparam int LINES_PER_FIELD_625 = 313;

    // Accepted window wide enough to cover both 525- and 625-line fields
    localparam int LINES_MIN_DEF     = 260;
    localparam int LINES_MAX_DEF     = 320;

    localparam int LOCK_FIELDS_DEF   = 2;
    localparam int UNLOCK_MISSES_DEF = 3;

    localparam int LINE_W_DEF        = 10;
    localparam int SAMPLE_W_DEF      = 11;
    localparam int WDOG_CLKS_DEF     = 4096;

    // Width of the good/miss field counters
    localparam int FLD_CNT_W         = 4;

    // Saturating increment for the good/miss field counters
    function automatic logic [FLD_CNT_W-1:0] fld_cnt_inc(input logic [FLD_CNT_W-1:0] cnt);
        logic [FLD_CNT_W-1:0] res;
        if (cnt == {FLD_CNT_W{1'b1}}) begin
            res = cnt;
        end else begin
            res = cnt + {{(FLD_CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Sync edge detector: remembers the previous H and F flags and flags
// H rising/falling and F toggle edges against the current inputs.
// Reset values are 1 to match the sync parser, so releasing reset with
// H = F = 1 produces no edge.
module sync_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic h_in,
    input  logic f_in,
    output logic h_rise,
    output logic h_fall,
    output logic f_edge
);

    logic h_q;
    logic h_d;
    logic f_q;
    logic f_d;

    // Next value of the remembered flags is simply the current input
    always_comb begin
        h_d = h_in;
        f_d = f_in;
    end

    // Previous-flag registers with parser-matching reset values
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h_q <= 1'b1;
            f_q <= 1'b1;
        end else begin
            h_q <= h_d;
            f_q <= f_d;
        end
    end

    assign h_rise = h_in & ~h_q;
    assign h_fall = ~h_in & h_q;
    assign f_edge = f_in ^ f_q;

endmodule

// File: rtl/field_lock_controller.sv
// Field lock controller: counts lines per field and samples per line from
// the BT.656 H/V/F flags, qualifies field length with a SEARCH/MEASURE/
// LOCKED state machine and drives registered timing strobes, the active
// video window and lock status to the line scrambler.
// Optional build macro FLC_SYNC_WATCHDOG_EN adds an H-activity watchdog
// (wd_cnt) that drops lock when H rising edges stop, reported on wdog_trip.
module field_lock_controller
    import video_timing_pkg::*;
#(
`ifdef FLC_SYNC_WATCHDOG_EN
    parameter int WDOG_CLKS     = WDOG_CLKS_DEF,
`endif
    parameter int LINES_MIN     = LINES_MIN_DEF,
    parameter int LINES_MAX     = LINES_MAX_DEF,
    parameter int LOCK_FIELDS   = LOCK_FIELDS_DEF,
    parameter int UNLOCK_MISSES = UNLOCK_MISSES_DEF,
    parameter int LINE_W        = LINE_W_DEF,
    parameter int SAMPLE_W      = SAMPLE_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                h_in,
    input  logic                v_in,
    input  logic                f_in,
    output logic [LINE_W-1:0]   line_cnt,
    output logic [SAMPLE_W-1:0] sample_cnt,
    output logic                field,
    output logic                line_start,
    output logic                field_start,
    output logic                active_video,
    output logic                locked,
`ifdef FLC_SYNC_WATCHDOG_EN
    output logic                wdog_trip,
`endif
    output logic [1:0]          lock_state
);

    localparam logic [LINE_W-1:0]    LINE_SAT     = {LINE_W{1'b1}};
    localparam logic [SAMPLE_W-1:0]  SAMPLE_SAT   = {SAMPLE_W{1'b1}};
    localparam logic [LINE_W-1:0]    LINES_MIN_V  = LINE_W'(LINES_MIN);
    localparam logic [LINE_W-1:0]    LINES_MAX_V  = LINE_W'(LINES_MAX);
    localparam logic [FLD_CNT_W-1:0] LOCK_FLD_V   = FLD_CNT_W'(LOCK_FIELDS);
    localparam logic [FLD_CNT_W-1:0] UNLOCK_MIS_V = FLD_CNT_W'(UNLOCK_MISSES);

    logic h_rise_s;
    logic h_fall_s;
    logic f_edge_s;
    logic field_good_s;
    logic wd_trip_s;

    logic [LINE_W-1:0]    line_cnt_q,   line_cnt_d;
    logic [SAMPLE_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic                 field_q,      field_d;
    logic                 line_start_q, line_start_d;
    logic                 field_start_q, field_start_d;
    logic                 active_video_q, active_video_d;
    logic                 locked_q,     locked_d;
    lock_state_e          state_q,      state_d;
    logic [FLD_CNT_W-1:0] good_cnt_q,   good_cnt_d;
    logic [FLD_CNT_W-1:0] miss_cnt_q,   miss_cnt_d;
    logic [FLD_CNT_W-1:0] good_inc_s;
    logic [FLD_CNT_W-1:0] miss_inc_s;

    sync_edge_detect u_sync_edge_detect (
        .clk     (clk),
        .reset_n (reset_n),
        .h_in    (h_in),
        .f_in    (f_in),
        .h_rise  (h_rise_s),
        .h_fall  (h_fall_s),
        .f_edge  (f_edge_s)
    );

    // A closing field is judged on its line count before the clear
    assign field_good_s = (line_cnt_q >= LINES_MIN_V) && (line_cnt_q <= LINES_MAX_V);
    assign good_inc_s   = fld_cnt_inc(good_cnt_q);
    assign miss_inc_s   = fld_cnt_inc(miss_cnt_q);

`ifdef FLC_SYNC_WATCHDOG_EN
    localparam int                WD_W      = $clog2(WDOG_CLKS + 1);
    localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(WDOG_CLKS);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            wdog_trip_q, wdog_trip_d;

    // Trip only matters while timing is being qualified or held
    assign wd_trip_s = (wd_cnt_q == WD_LIMIT) && (state_q != LS_SEARCH);

    // Watchdog counts clocks since the last H rise, parked at the limit
    always_comb begin
        wd_cnt_d    = wd_cnt_q;
        wdog_trip_d = wd_trip_s;
        if (h_rise_s || wd_trip_s) begin
            wd_cnt_d = {WD_W{1'b0}};
        end else if (wd_cnt_q != WD_LIMIT) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end else begin
            wd_cnt_d = wd_cnt_q;
        end
    end

    // Watchdog registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wd_cnt_q    <= {WD_W{1'b0}};
            wdog_trip_q <= 1'b0;
        end else begin
            wd_cnt_q    <= wd_cnt_d;
            wdog_trip_q <= wdog_trip_d;
        end
    end

    assign wdog_trip = wdog_trip_q;
`else
    assign wd_trip_s = 1'b0;
`endif

    // Line/sample counters, field id and timing strobes
    always_comb begin
        line_cnt_d    = line_cnt_q;
        sample_cnt_d  = sample_cnt_q;
        field_d       = field_q;
        line_start_d  = h_fall_s;
        field_start_d = f_edge_s;

        // Field edge beats a coincident H rise: that rise is not counted
        if (f_edge_s) begin
            line_cnt_d = {LINE_W{1'b0}};
            field_d    = f_in;
        end else if (h_rise_s && (line_cnt_q != LINE_SAT)) begin
            line_cnt_d = line_cnt_q + LINE_W'(1);
        end else begin
            line_cnt_d = line_cnt_q;
        end

        if (h_fall_s) begin
            sample_cnt_d = {SAMPLE_W{1'b0}};
        end else if (sample_cnt_q != SAMPLE_SAT) begin
            sample_cnt_d = sample_cnt_q + SAMPLE_W'(1);
        end else begin
            sample_cnt_d = sample_cnt_q;
        end
    end

    // Lock FSM next state and field counters; watchdog trip overrides f_edge
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        miss_cnt_d = miss_cnt_q;

        if (wd_trip_s) begin
            state_d    = LS_SEARCH;
            good_cnt_d = {FLD_CNT_W{1'b0}};
            miss_cnt_d = {FLD_CNT_W{1'b0}};
        end else if (f_edge_s) begin
            case (state_q)
                LS_SEARCH: begin
                    // First edge only opens a partial field; it is not judged
                    state_d    = LS_MEASURE;
                    good_cnt_d = {FLD_CNT_W{1'b0}};
                end
                LS_MEASURE: begin
                    if (field_good_s) begin
                        good_cnt_d = good_inc_s;
                        if (good_inc_s == LOCK_FLD_V) begin
                            state_d    = LS_LOCKED;
                            miss_cnt_d = {FLD_CNT_W{1'b0}};
                        end else begin
                            state_d    = LS_MEASURE;
                        end
                    end else begin
                        good_cnt_d = {FLD_CNT_W{1'b0}};
                    end
                end
                LS_LOCKED: begin
                    if (field_good_s) begin
                        miss_cnt_d = {FLD_CNT_W{1'b0}};
                    end else if (miss_inc_s == UNLOCK_MIS_V) begin
                        state_d    = LS_SEARCH;
                        good_cnt_d = {FLD_CNT_W{1'b0}};
                        miss_cnt_d = {FLD_CNT_W{1'b0}};
                    end else begin
                        miss_cnt_d = miss_inc_s;
                    end
                end
                default: begin
                    state_d    = LS_SEARCH;
                    good_cnt_d = {FLD_CNT_W{1'b0}};
                    miss_cnt_d = {FLD_CNT_W{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Lock status and video window follow the next state so they move together
    always_comb begin
        locked_d       = (state_d == LS_LOCKED);
        active_video_d = ~h_in & ~v_in & locked_d;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            line_cnt_q     <= {LINE_W{1'b0}};
            sample_cnt_q   <= {SAMPLE_W{1'b0}};
            field_q        <= 1'b0;
            line_start_q   <= 1'b0;
            field_start_q  <= 1'b0;
            active_video_q <= 1'b0;
            locked_q       <= 1'b0;
            state_q        <= LS_SEARCH;
            good_cnt_q     <= {FLD_CNT_W{1'b0}};
            miss_cnt_q     <= {FLD_CNT_W{1'b0}};
        end else begin
            line_cnt_q     <= line_cnt_d;
            sample_cnt_q   <= sample_cnt_d;
            field_q        <= field_d;
            line_start_q   <= line_start_d;
            field_start_q  <= field_start_d;
            active_video_q <= active_video_d;
            locked_q       <= locked_d;
            state_q        <= state_d;
            good_cnt_q     <= good_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
        end
    end

    assign line_cnt     = line_cnt_q;
    assign sample_cnt   = sample_cnt_q;
    assign field        = field_q;
    assign line_start   = line_start_q;
    assign field_start  = field_start_q;
    assign active_video = active_video_q;
    assign locked       = locked_q;
    assign lock_state   = state_q;

endmodule

// File: tb/tb_field_lock_controller.sv
// Self-checking bench for field_lock_controller: a table of field lengths
// with expected lock state, hand-written corner sequences, and randomized
// line/field timing compared every cycle against a behavioural model.
module tb_field_lock_controller;

    localparam int L_MIN = 260;
    localparam int L_MAX = 320;
    localparam int N_LOCK = 2;
    localparam int N_MISS = 3;
    localparam int LINE_SAT = 1023;
    localparam int SMP_SAT = 2047;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        h_in = 1'b1;
    logic        v_in = 1'b1;
    logic        f_in = 1'b1;
    logic [9:0]  line_cnt;
    logic [10:0] sample_cnt;
    logic        field, line_start, field_start, active_video, locked;
    logic [1:0]  lock_state;
`ifdef FLC_SYNC_WATCHDOG_EN
    logic        wdog_trip;
`endif

    field_lock_controller dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .h_in         (h_in),
        .v_in         (v_in),
        .f_in         (f_in),
        .line_cnt     (line_cnt),
        .sample_cnt   (sample_cnt),
        .field        (field),
        .line_start   (line_start),
        .field_start  (field_start),
        .active_video (active_video),
        .locked       (locked),
`ifdef FLC_SYNC_WATCHDOG_EN
        .wdog_trip    (wdog_trip),
`endif
        .lock_state   (lock_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b1;
    logic f_cur = 1'b1;

    // behavioural reference model state
    bit m_hq, m_fq, m_field, m_ls, m_fs, m_av, m_locked;
    int m_line, m_sample, m_state, m_good, m_miss;

    typedef struct {
        int lines;
        bit coincide;
        int exp_state;
        bit exp_locked;
    } field_vec_t;

    field_vec_t tbl[20];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit rise, fall, fe, good;
        if (!reset_n) begin
            m_hq = 1'b1; m_fq = 1'b1; m_field = 1'b0; m_ls = 1'b0; m_fs = 1'b0;
            m_av = 1'b0; m_locked = 1'b0; m_line = 0; m_sample = 0;
            m_state = 0; m_good = 0; m_miss = 0;
        end else begin
            rise = h_in && !m_hq;
            fall = !h_in && m_hq;
            fe   = (f_in != m_fq);
            if (fe) begin
                good = (m_line >= L_MIN) && (m_line <= L_MAX);
                if (m_state == 0) begin
                    m_state = 1; m_good = 0;
                end else if (m_state == 1) begin
                    if (good) begin
                        m_good++;
                        if (m_good == N_LOCK) begin m_state = 2; m_miss = 0; end
                    end else m_good = 0;
                end else begin
                    if (good) m_miss = 0;
                    else begin
                        m_miss++;
                        if (m_miss == N_MISS) begin m_state = 0; m_good = 0; end
                    end
                end
                m_line = 0;
                m_field = f_in;
            end else if (rise && m_line < LINE_SAT) begin
                m_line++;
            end
            m_sample = fall ? 0 : ((m_sample < SMP_SAT) ? m_sample + 1 : SMP_SAT);
            m_ls = fall;
            m_fs = fe;
            m_locked = (m_state == 2);
            m_av = !h_in && !v_in && m_locked;
            m_hq = h_in;
            m_fq = f_in;
        end
    endtask

    task automatic compare_model();
        checks++;
        if (line_cnt !== 10'(m_line) || sample_cnt !== 11'(m_sample) || field !== m_field ||
            line_start !== m_ls || field_start !== m_fs || active_video !== m_av ||
            locked !== m_locked || lock_state !== 2'(m_state)) begin
            errors++;
            $display("FAIL model t=%0t got line=%0d smp=%0d fld=%0b ls=%0b fs=%0b av=%0b lk=%0b st=%0d expected line=%0d smp=%0d fld=%0b ls=%0b fs=%0b av=%0b lk=%0b st=%0d",
                     $time, line_cnt, sample_cnt, field, line_start, field_start, active_video, locked, lock_state,
                     m_line, m_sample, m_field, m_ls, m_fs, m_av, m_locked, m_state);
        end
    endtask

    // drive one clock of inputs, advance the model, compare #1 after the edge
    task automatic step(input logic h, input logic v, input logic f);
        h_in = h; v_in = v; f_in = f;
        @(posedge clk);
        model_update();
        #1;
        if (chk_en) compare_model();
    endtask

    task automatic gen_line(input logic v);
        step(1'b1, v, f_cur);
        step(1'b0, v, f_cur);
        step(1'b0, v, f_cur);
    endtask

    // n lines, then an F toggle (together with an H rise when coincide)
    task automatic gen_field(input int n, input bit coincide);
        for (int i = 0; i < n; i++) gen_line(1'b0);
        f_cur = ~f_cur;
        step(coincide, 1'b0, f_cur);
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        f_cur = 1'b1;
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1);
        reset_n = 1'b1;
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // {lines, coincide, expected lock_state, expected locked} after the closing edge
        tbl[0]  = '{263, 1'b0, 1, 1'b0};
        tbl[1]  = '{263, 1'b0, 2, 1'b1};
        tbl[2]  = '{200, 1'b0, 2, 1'b1};
        tbl[3]  = '{262, 1'b1, 2, 1'b1};
        tbl[4]  = '{200, 1'b0, 2, 1'b1};
        tbl[5]  = '{200, 1'b0, 2, 1'b1};
        tbl[6]  = '{263, 1'b0, 2, 1'b1};
        tbl[7]  = '{200, 1'b0, 2, 1'b1};
        tbl[8]  = '{200, 1'b0, 2, 1'b1};
        tbl[9]  = '{200, 1'b0, 0, 1'b0};
        tbl[10] = '{320, 1'b0, 1, 1'b0};
        tbl[11] = '{300, 1'b0, 1, 1'b0};
        tbl[12] = '{320, 1'b1, 2, 1'b1};
        tbl[13] = '{259, 1'b0, 2, 1'b1};
        tbl[14] = '{259, 1'b0, 2, 1'b1};
        tbl[15] = '{259, 1'b0, 0, 1'b0};
        tbl[16] = '{260, 1'b0, 1, 1'b0};
        tbl[17] = '{321, 1'b0, 1, 1'b0};
        tbl[18] = '{260, 1'b0, 1, 1'b0};
        tbl[19] = '{260, 1'b0, 2, 1'b1};

        // reset held 5 clocks with H = V = F = 1
        do_reset(5);
        check("rst_line_cnt", int'(line_cnt), 0);
        check("rst_sample_cnt", int'(sample_cnt), 0);
        check("rst_lock_state", int'(lock_state), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_active_video", int'(active_video), 0);
        check("rst_field", int'(field), 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1);
            check("rel_line_start", int'(line_start), 0);
            check("rel_field_start", int'(field_start), 0);
        end

        // partial first field: SEARCH -> MEASURE on the first F edge
        step(1'b0, 1'b0, 1'b1);
        f_cur = 1'b0;
        step(1'b0, 1'b0, f_cur);
        check("first_edge_state", int'(lock_state), 1);
        check("first_edge_fs", int'(field_start), 1);
        check("first_edge_field", int'(field), 0);

        // table of field lengths
        for (int k = 0; k < 20; k++) begin
            gen_field(tbl[k].lines, tbl[k].coincide);
            check($sformatf("tbl%0d_state", k), int'(lock_state), tbl[k].exp_state);
            check($sformatf("tbl%0d_locked", k), int'(locked), int'(tbl[k].exp_locked));
            check($sformatf("tbl%0d_fs", k), int'(field_start), 1);
            check($sformatf("tbl%0d_line0", k), int'(line_cnt), 0);
            if (tbl[k].coincide) begin
                step(1'b0, 1'b0, f_cur);
                check($sformatf("tbl%0d_coin_line", k), int'(line_cnt), 0);
            end
        end

        // SAV strobe, sample counter restart and active video while locked
        step(1'b1, 1'b0, f_cur);
        check("sav_av_blank", int'(active_video), 0);
        step(1'b0, 1'b0, f_cur);
        check("sav_line_start", int'(line_start), 1);
        check("sav_sample0", int'(sample_cnt), 0);
        check("sav_active_video", int'(active_video), 1);
        step(1'b0, 1'b0, f_cur);
        check("sav_sample1", int'(sample_cnt), 1);
        check("sav_ls_pulse", int'(line_start), 0);
        step(1'b0, 1'b0, f_cur);
        check("sav_sample2", int'(sample_cnt), 2);
        step(1'b0, 1'b1, f_cur);
        check("vblank_av", int'(active_video), 0);

        // sample counter saturation with H held in blanking
        for (int i = 0; i < 2100; i++) step(1'b1, 1'b0, f_cur);
        check("sample_sat", int'(sample_cnt), SMP_SAT);
        check("hold_locked", int'(locked), 1);

        // line counter saturation with no F activity
        for (int i = 0; i < 1030; i++) gen_line(1'b0);
        check("line_sat", int'(line_cnt), LINE_SAT);

        // mid-operation reset while locked
        do_reset(1);
        check("midrst_state", int'(lock_state), 0);
        check("midrst_locked", int'(locked), 0);
        check("midrst_line", int'(line_cnt), 0);

        // randomized line shapes and field lengths around the accepted window
        step(1'b0, 1'b0, f_cur);
        f_cur = ~f_cur;
        step(1'b0, 1'b0, f_cur);
        for (int k = 0; k < 12; k++) begin
            int n;
            bit coin;
            n = $urandom_range(325, 255);
            coin = ($urandom_range(3, 0) == 0);
            for (int i = 0; i < n; i++) begin
                logic vv;
                int hi, lo;
                vv = ($urandom_range(7, 0) == 0);
                hi = $urandom_range(3, 1);
                lo = $urandom_range(3, 1);
                for (int j = 0; j < hi; j++) step(1'b1, vv, f_cur);
                for (int j = 0; j < lo; j++) step(1'b0, vv, f_cur);
            end
            f_cur = ~f_cur;
            step(coin, 1'b0, f_cur);
            if (coin) step(1'b0, 1'b0, f_cur);
        end

`ifdef FLC_SYNC_WATCHDOG_EN
        // watchdog: lock, then stop H activity
        begin
            bit seen;
            seen = 1'b0;
            chk_en = 1'b0;
            do_reset(2);
            step(1'b0, 1'b0, f_cur);
            f_cur = ~f_cur;
            step(1'b0, 1'b0, f_cur);
            gen_field(263, 1'b0);
            gen_field(263, 1'b0);
            check("wd_pre_locked", int'(locked), 1);
            step(1'b1, 1'b0, f_cur);
            for (int i = 0; i < 5000 && !seen; i++) begin
                step(1'b1, 1'b0, f_cur);
                if (wdog_trip === 1'b1) seen = 1'b1;
            end
            check("wd_trip_seen", int'(seen), 1);
            check("wd_state", int'(lock_state), 0);
            check("wd_locked", int'(locked), 0);
            step(1'b1, 1'b0, f_cur);
            check("wd_trip_pulse", int'(wdog_trip), 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
